// File: rtl/src_io_ports_if.sv
// CPU-side and device-side signal bundle for src_io_ports.
// The master modport is the surrounding system; the slave modport is the port block.
interface src_io_ports_if #(
   parameter int DATA_W = 32,
   parameter int N_IN   = 4,
   parameter int N_OUT  = 4,
   parameter int SEL_W  = 4
);
   logic [SEL_W-1:0]        io_sel;
   logic                    in_rd;
   logic                    out_wr;
   logic [DATA_W-1:0]       bus_in;
   logic [DATA_W-1:0]       bus_out;
   logic                    io_stall;

   logic [N_IN-1:0]         in_valid;
   logic [N_IN*DATA_W-1:0]  in_data;
   logic [N_IN-1:0]         in_ready;

   logic [N_OUT-1:0]        out_valid;
   logic [N_OUT*DATA_W-1:0] out_data;
   logic [N_OUT-1:0]        out_ready;

   modport master (
      output io_sel, in_rd, out_wr, bus_in, in_valid, in_data, out_ready,
      input  bus_out, io_stall, in_ready, out_valid, out_data
   );

   modport slave (
      input  io_sel, in_rd, out_wr, bus_in, in_valid, in_data, out_ready,
      output bus_out, io_stall, in_ready, out_valid, out_data
   );
endinterface

// File: rtl/src_io_ports.sv
// Multi-channel I/O port block for the Mini SRC: N_IN buffered input FIFOs, N_OUT handshaked output registers.
// Define SRC_IO_BYPASS_EN to let a read of an empty FIFO take the device word directly in the same cycle.
module src_io_ports #(
   parameter int DATA_W     = 32,
   parameter int N_IN       = 4,
   parameter int N_OUT      = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int SEL_W      = 4
) (
   input logic           clk,
   input logic           rst_n,
   src_io_ports_if.slave io
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [N_IN-1:0][DATA_W-1:0] rd_word;
   logic [N_IN-1:0]             rd_stall;
   logic [N_OUT-1:0]            wr_stall;

   for (genvar k = 0; k < N_IN; k++) begin : g_in
      logic [PTR_W-1:0]  rd_ptr;
      logic [PTR_W-1:0]  wr_ptr;
      logic [CNT_W-1:0]  count;
      logic [DATA_W-1:0] mem [FIFO_DEPTH];
      logic              sel_hit;
      logic              empty;
      logic              full;
      logic              pop;
      logic              push;
      logic              bypass;

      assign sel_hit = io.in_rd && (io.io_sel == SEL_W'(k));
      assign empty   = (count == '0);
      assign full    = (count == CNT_W'(FIFO_DEPTH));
      assign pop     = sel_hit && !empty;

`ifdef SRC_IO_BYPASS_EN
      assign bypass  = sel_hit && empty && io.in_valid[k];
`else
      assign bypass  = 1'b0;
`endif

      // A bypassed word goes straight to the CPU and never occupies a slot.
      assign io.in_ready[k] = !full || bypass;
      assign push           = io.in_valid[k] && io.in_ready[k] && !bypass;
      assign rd_stall[k]    = sel_hit && empty && !bypass;
      assign rd_word[k]     = pop    ? mem[rd_ptr] :
                              bypass ? io.in_data[k*DATA_W +: DATA_W] : '0;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
               count <= count + 1'b1;
            else if (pop && !push)
               count <= count - 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (push)
            mem[wr_ptr] <= io.in_data[k*DATA_W +: DATA_W];
      end
   end

   for (genvar j = 0; j < N_OUT; j++) begin : g_out
      logic              wr_hit;
      logic              accept;
      logic              valid_q;
      logic [DATA_W-1:0] data_q;

      // A simultaneous read wins, so the write strobe is ignored whenever in_rd is high.
      assign wr_hit      = io.out_wr && !io.in_rd && (io.io_sel == SEL_W'(j));
      assign accept      = wr_hit && (!valid_q || io.out_ready[j]);
      assign wr_stall[j] = wr_hit && !accept;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= io.bus_in;
         end else if (valid_q && io.out_ready[j]) begin
            valid_q <= 1'b0;
         end
      end

      assign io.out_valid[j]                   = valid_q;
      assign io.out_data[j*DATA_W +: DATA_W]   = data_q;
   end

   // At most one channel is selected, so OR-merging the per-channel results is exact.
   always_comb begin
      io.bus_out  = '0;
      io.io_stall = |wr_stall;
      for (int k = 0; k < N_IN; k++) begin
         io.bus_out  = io.bus_out | rd_word[k];
         io.io_stall = io.io_stall | rd_stall[k];
      end
   end
endmodule
